scope_trigger_capture: RTL

- Parametrised trigger-and-capture engine for the oscilloscope datapath. Sits between the ADC sample stream and the VGA renderer.
- Accepts NUM_CH channels per sample and decimates by 2^time_div (time per division).
- Triggers on a level crossing of a selected channel with selectable slope, in normal or auto mode.
- Stores a pre/post-trigger frame in a ring buffer. The renderer reads the frame by logical address, oldest sample first.

---
 rtl/scope_pkg.sv | 28 ++
 rtl/scope_trig_detect.sv | 59 +++++
 rtl/scope_trigger_capture.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/scope_pkg.sv
// Shared types, constants and width helpers for the scope trigger/capture engine.
// Optional hysteresis is enabled with SCOPE_TRIG_HYST_EN (see scope_trig_detect).
package scope_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      ARMED,
      POST,
      DONE
   } state_t;

   localparam logic SLOPE_RISE  = 1'b0;
   localparam logic SLOPE_FALL  = 1'b1;
   localparam logic MODE_NORMAL = 1'b0;
   localparam logic MODE_AUTO   = 1'b1;

   // Bits needed to hold 0..n-1, never less than 1.
   function automatic int min1_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Decimation counter must reach 2^(2^div_w - 1) - 1.
   function automatic int dec_w(input int div_w);
      return (div_w > 0) ? (1 << div_w) - 1 : 1;
   endfunction

endpackage

// File: rtl/scope_trig_detect.sv
// Level-crossing trigger detector on the kept-sample stream of one channel.
// Defining SCOPE_TRIG_HYST_EN adds a fixed hysteresis band around the level.
module scope_trig_detect
   import scope_pkg::*;
#(
   parameter int SAMPLE_W = 8
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                kept,
   input  logic [SAMPLE_W-1:0] cur,
   input  logic [SAMPLE_W-1:0] level,
   input  logic                slope,
   output logic                trig_hit
);

   logic [SAMPLE_W-1:0] prev;
   logic                prev_valid;
   logic [SAMPLE_W-1:0] lo;
   logic [SAMPLE_W-1:0] hi;

`ifdef SCOPE_TRIG_HYST_EN
   localparam int HYST = 2;
   localparam logic [SAMPLE_W-1:0] H = SAMPLE_W'(HYST);

   // Band edges saturate at 0 and at full scale.
   always_comb begin
      lo = (level >= H) ? level - H : '0;
      hi = (level <= ~H) ? level + H : '1;
   end
`else
   assign lo = level;
   assign hi = level;
`endif

   always_comb begin
      trig_hit = 1'b0;
      if (kept && prev_valid) begin
         if (slope == SLOPE_FALL)
            trig_hit = (prev > hi) && (cur <= level);
         else
            trig_hit = (prev < lo) && (cur >= level);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev       <= '0;
         prev_valid <= 1'b0;
      end else if (clear) begin
         prev_valid <= 1'b0;
      end else if (kept) begin
         prev       <= cur;
         prev_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/scope_trigger_capture.sv
// Trigger-and-capture engine: decimation, trigger FSM and pre/post ring buffer.
// Build with SCOPE_TRIG_HYST_EN defined to enable trigger hysteresis.
module scope_trigger_capture
   import scope_pkg::*;
#(
   parameter int NUM_CH       = 2,
   parameter int SAMPLE_W     = 8,
   parameter int DEPTH_LOG2   = 9,
   parameter int PRE_TRIG     = 128,
   parameter int DIV_W        = 4,
   parameter int AUTO_TIMEOUT = 1024
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           sample_valid,
   input  logic [NUM_CH*SAMPLE_W-1:0]     sample_data,
   input  logic [min1_clog2(NUM_CH)-1:0]  trig_sel,
   input  logic [SAMPLE_W-1:0]            trig_level,
   input  logic                           trig_slope,
   input  logic                           trig_mode,
   input  logic [DIV_W-1:0]               time_div,
   input  logic                           rearm,
   input  logic [DEPTH_LOG2-1:0]          rd_addr,
   output logic [NUM_CH*SAMPLE_W-1:0]     rd_data,
   output logic                           frame_ready,
   output logic                           capturing,
   output logic                           trig_forced
);

   localparam int DEPTH    = 1 << DEPTH_LOG2;
   localparam int DW       = NUM_CH * SAMPLE_W;
   localparam int POST_LEN = DEPTH - PRE_TRIG;
   localparam int DEC_W    = dec_w(DIV_W);
   localparam int PT_W     = min1_clog2(PRE_TRIG);
   localparam int TO_W     = min1_clog2(AUTO_TIMEOUT);
   localparam int PL_W     = min1_clog2(POST_LEN);

   localparam logic [PT_W-1:0]       FILL_LAST = PT_W'(PRE_TRIG - 1);
   localparam logic [TO_W-1:0]       TO_LAST   = TO_W'(AUTO_TIMEOUT - 1);
   localparam logic [PL_W-1:0]       POST_LAST = PL_W'(POST_LEN - 1);
   localparam logic [DEPTH_LOG2-1:0] PRE_OFS   = DEPTH_LOG2'(PRE_TRIG);

   state_t                state;
   logic [DEC_W-1:0]      dec_cnt;
   logic [DEC_W-1:0]      dec_mask;
   logic                  kept;
   logic                  we;
   logic                  trig_hit;
   logic                  timeout_hit;
   logic [SAMPLE_W-1:0]   cur;
   logic [SAMPLE_W-1:0]   chans [NUM_CH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] start_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [PT_W-1:0]       fill_cnt;
   logic [TO_W-1:0]       timeout_cnt;
   logic [PL_W-1:0]       post_cnt;
   logic [DW-1:0]         mem [DEPTH];

   always_comb begin
      for (int k = 0; k < NUM_CH; k++)
         chans[k] = sample_data[k*SAMPLE_W +: SAMPLE_W];
   end

   assign cur      = chans[trig_sel];
   assign dec_mask = ~({DEC_W{1'b1}} << time_div);
   assign kept     = sample_valid && (dec_cnt == '0);

   // ">=" lets a time_div shrink mid-run wrap cleanly instead of overrunning.
   always_ff @(posedge clk) begin
      if (rst || rearm)
         dec_cnt <= '0;
      else if (sample_valid)
         dec_cnt <= (dec_cnt >= dec_mask) ? '0 : dec_cnt + DEC_W'(1);
   end

   scope_trig_detect #(
      .SAMPLE_W (SAMPLE_W)
   ) u_trig (
      .clk      (clk),
      .rst      (rst),
      .clear    (rearm),
      .kept     (kept),
      .cur      (cur),
      .level    (trig_level),
      .slope    (trig_slope),
      .trig_hit (trig_hit)
   );

   assign timeout_hit = (trig_mode == MODE_AUTO) && (timeout_cnt == TO_LAST);

   always_comb begin
      we = 1'b0;
      if (!rst && !rearm && kept)
         we = (state == FILL) || (state == ARMED) || (state == POST);
   end

   always_ff @(posedge clk) begin
      if (we)
         mem[wr_ptr] <= sample_data;
   end

   assign rd_ptr = start_ptr + rd_addr;

   always_ff @(posedge clk) begin
      if (rst)
         rd_data <= '0;
      else
         rd_data <= mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         frame_ready <= 1'b0;
         capturing   <= 1'b0;
         trig_forced <= 1'b0;
         wr_ptr      <= '0;
         start_ptr   <= '0;
         fill_cnt    <= '0;
         timeout_cnt <= '0;
         post_cnt    <= '0;
      end else if (rearm) begin
         state       <= FILL;
         frame_ready <= 1'b0;
         capturing   <= 1'b1;
         fill_cnt    <= '0;
      end else if (kept) begin
         unique case (state)
            FILL: begin
               wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
               if (fill_cnt == FILL_LAST) begin
                  state       <= ARMED;
                  timeout_cnt <= '0;
               end else begin
                  fill_cnt <= fill_cnt + PT_W'(1);
               end
            end
            ARMED: begin
               wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
               if (trig_hit || timeout_hit) begin
                  start_ptr   <= wr_ptr - PRE_OFS;
                  trig_forced <= !trig_hit;
                  post_cnt    <= PL_W'(1);
                  if (POST_LEN == 1) begin
                     state       <= DONE;
                     frame_ready <= 1'b1;
                     capturing   <= 1'b0;
                  end else begin
                     state <= POST;
                  end
               end else if (timeout_cnt != TO_LAST) begin
                  timeout_cnt <= timeout_cnt + TO_W'(1);
               end
            end
            POST: begin
               wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
               if (post_cnt == POST_LAST) begin
                  state       <= DONE;
                  frame_ready <= 1'b1;
                  capturing   <= 1'b0;
               end else begin
                  post_cnt <= post_cnt + PL_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
